mm_result_collector: RTL and testbench

MM_RESULT_COLLECTOR -- requirements
Module: mm_result_collector

---
 rtl/mm_result_collector.sv | 133 +++++++++++++
 tb/tb_mm_result_collector.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_result_collector.sv
// Collects per-column matrix results written out of order into a row store
// and streams completed rows out strictly in row order with valid/ready.
module mm_result_collector #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROW_NUM    = 32,
  parameter int unsigned COL_NUM    = 32,
  localparam int unsigned ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [DATA_WIDTH*COL_NUM-1:0]     col_data,
  input  logic [ROW_ADDR_WIDTH*COL_NUM-1:0] col_wraddr,
  input  logic [COL_NUM-1:0]               col_wr_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*COL_NUM-1:0]     out_data,
  output logic [ROW_ADDR_WIDTH-1:0]         out_row,
  output logic                             done,
  output logic                             err
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state, state_nxt;
  logic   done_nxt;

  logic [DATA_WIDTH-1:0]     store   [ROW_NUM][COL_NUM];
  logic [COL_NUM-1:0]        written [ROW_NUM];
  logic [ROW_ADDR_WIDTH-1:0] ptr;

  logic [ROW_ADDR_WIDTH-1:0] addr [COL_NUM];
  logic [COL_NUM-1:0]        wr_ok;
  logic [ROW_NUM-1:0]        row_full;
  logic                      wr_err;
  logic                      accept;
  logic                      last;
  logic [ROW_ADDR_WIDTH-1:0] cand_row;

  // Per-column write qualification: only fresh, in-range writes during RUN land.
  always_comb begin
    wr_ok  = '0;
    wr_err = 1'b0;
    for (int i = 0; i < COL_NUM; i++) begin
      addr[i] = col_wraddr[i*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH];
      if (col_wr_en[i]) begin
        if (state != RUN) begin
          wr_err = 1'b1;
        end else if (32'(addr[i]) >= ROW_NUM || written[addr[i]][i]) begin
          wr_err = 1'b1;
        end else begin
          wr_ok[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < ROW_NUM; r++) begin
      row_full[r] = &written[r];
    end
  end

  assign accept   = out_valid && out_ready;
  assign last     = (ptr == ROW_ADDR_WIDTH'(ROW_NUM - 1));
  // Row to present after this edge: the pointed row, or its successor on acceptance.
  assign cand_row = accept ? ROW_ADDR_WIDTH'(ptr + 1'b1) : ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    done_nxt = (state_nxt == FIN);
  end

  // Result store carries no reset; the bitmap alone defines what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < COL_NUM; i++) begin
      if (wr_ok[i]) store[addr[i]][i] <= col_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int r = 0; r < ROW_NUM; r++) written[r] <= '0;
    end else begin
      err  <= err | wr_err;
      done <= done_nxt;
      if (state == IDLE && start) begin
        ptr       <= '0;
        out_valid <= 1'b0;
        for (int r = 0; r < ROW_NUM; r++) written[r] <= '0;
      end else if (state == RUN) begin
        if (accept) written[ptr] <= '0;
        for (int i = 0; i < COL_NUM; i++) begin
          if (wr_ok[i]) written[addr[i]][i] <= 1'b1;
        end
        if (accept && last) begin
          out_valid <= 1'b0;
          ptr       <= '0;
        end else if (!out_valid || accept) begin
          if (accept) ptr <= cand_row;
          if (row_full[cand_row]) begin
            out_valid <= 1'b1;
            out_row   <= cand_row;
            for (int i = 0; i < COL_NUM; i++) begin
              out_data[i*DATA_WIDTH +: DATA_WIDTH] <= store[cand_row][i];
            end
          end else begin
            out_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mm_result_collector.sv
// Directed bench for mm_result_collector (4x4x8) with an edge-timing reference model.
module tb_mm_result_collector;

  localparam int unsigned DW = 8;
  localparam int unsigned RN = 4;
  localparam int unsigned CN = 4;
  localparam int unsigned AW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DW*CN-1:0]  col_data;
  logic [AW*CN-1:0]  col_wraddr;
  logic [CN-1:0]     col_wr_en;
  logic              out_valid;
  logic              out_ready;
  logic [DW*CN-1:0]  out_data;
  logic [AW-1:0]     out_row;
  logic              done;
  logic              err;

  mm_result_collector #(.DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN)) dut (
    .clk(clk), .reset(reset), .start(start), .col_data(col_data),
    .col_wraddr(col_wraddr), .col_wr_en(col_wr_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Row r, column c carries r*16+c, so each packed row is a fixed literal.
  logic [31:0] rowd [4];
  initial begin
    rowd[0] = 32'h03020100;
    rowd[1] = 32'h13121110;
    rowd[2] = 32'h23222120;
    rowd[3] = 32'h33323130;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a row is shown from edge max(completion_edge+1, pointer_arrival_edge).
  int          n;
  int          ph;         // 0 idle, 1 run, 2 fin
  int          prev_ph;
  int          mptr;
  int          ptr_edge;
  int          ce [4];
  bit          mwr [4][4];
  logic [7:0]  mdat [4][4];
  bit          macc;
  bit          full;
  int          r;
  logic        exp_valid, exp_done, exp_err;
  logic [1:0]  exp_row;
  logic [31:0] exp_data;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n = 0; ph = 0; mptr = 0; ptr_edge = 0;
      exp_valid = 0; exp_done = 0; exp_err = 0; exp_row = 0; exp_data = 0;
      for (int a = 0; a < 4; a++) begin
        ce[a] = -1;
        for (int b = 0; b < 4; b++) mwr[a][b] = 0;
      end
    end else begin
      n++;
      prev_ph  = ph;
      macc     = exp_valid && out_ready;
      exp_done = 0;
      for (int c = 0; c < 4; c++) begin
        if (col_wr_en[c]) begin
          r = int'(col_wraddr[2*c +: 2]);
          if (prev_ph != 1 || r >= 4 || mwr[r][c]) begin
            exp_err = 1;
          end else begin
            mwr[r][c]  = 1;
            mdat[r][c] = col_data[8*c +: 8];
            full = 1;
            for (int b = 0; b < 4; b++) if (!mwr[r][b]) full = 0;
            if (full) ce[r] = n;
          end
        end
      end
      if (prev_ph == 0 && start) begin
        ph = 1; mptr = 0; ptr_edge = n;
        for (int a = 0; a < 4; a++) begin
          ce[a] = -1;
          for (int b = 0; b < 4; b++) mwr[a][b] = 0;
        end
      end else if (prev_ph == 2) begin
        ph = 0;
      end else if (prev_ph == 1 && macc) begin
        for (int b = 0; b < 4; b++) mwr[mptr][b] = 0;
        ce[mptr] = -1;
        if (mptr == 3) begin
          ph = 2; exp_done = 1;
        end else begin
          mptr++; ptr_edge = n;
        end
      end
      exp_valid = (ph == 1) && (ce[mptr] >= 0) &&
                  (n >= ((ce[mptr] + 1 > ptr_edge) ? ce[mptr] + 1 : ptr_edge));
      if (exp_valid) begin
        exp_row  = 2'(mptr);
        exp_data = {mdat[mptr][3], mdat[mptr][2], mdat[mptr][1], mdat[mptr][0]};
      end
    end
  end

  int          row_q  [$];
  logic [31:0] data_q [$];

  // Cycle compare against the model, plus a log of rows the consumer accepted.
  always @(negedge clk) begin
    if (reset) begin
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("done", 32'(done), 32'(exp_done));
      chk("err", 32'(err), 32'(exp_err));
      if (exp_valid) begin
        chk("out_row", 32'(out_row), 32'(exp_row));
        chk("out_data", out_data, exp_data);
      end
      if (out_valid && out_ready) begin
        row_q.push_back(int'(out_row));
        data_q.push_back(out_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wcycle(input logic [7:0] addrs, input logic [3:0] en, input logic [7:0] flip = 8'h00);
    logic [1:0] ra;
    for (int c = 0; c < 4; c++) begin
      ra = addrs[2*c +: 2];
      col_data[8*c +: 8] = ({ra, 4'h0} + 8'(c)) ^ flip;
    end
    col_wraddr = addrs;
    col_wr_en  = en;
    step();
    col_wr_en  = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic full_rows();
    wcycle(8'h00, 4'hF);
    wcycle(8'h55, 4'hF);
    wcycle(8'hAA, 4'hF);
    wcycle(8'hFF, 4'hF);
  endtask

  task automatic wait_done(input string name);
    int pulses = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (done) pulses++;
    end
    chk(name, 32'(pulses), 32'd1);
  endtask

  task automatic check_queue(input string name);
    chk({name, "_count"}, 32'(row_q.size()), 32'd4);
    for (int i = 0; i < row_q.size() && i < 4; i++) begin
      chk({name, "_row"}, 32'(row_q[i]), 32'(i));
      chk({name, "_data"}, data_q[i], rowd[i]);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    col_data = '0; col_wraddr = '0; col_wr_en = '0;
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_row", 32'(out_row), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    step();

    // Basic in-order collection
    out_ready = 1'b1;
    row_q.delete(); data_q.delete();
    pulse_start();
    full_rows();
    wait_done("basic_done");
    check_queue("basic");
    chk("basic_err", 32'(err), 32'd0);

    // Out-of-order, columns of a row spread across cycles
    row_q.delete(); data_q.delete();
    pulse_start();
    wcycle(8'hFF, 4'hF);
    wcycle(8'h05, 4'hF);
    wcycle(8'h50, 4'b1101);
    wcycle(8'hA2, 4'hF);
    wcycle(8'hAA, 4'b0010);
    wait_done("ooo_done");
    check_queue("ooo");

    // Backpressure on row 0, then no-bubble handoff to row 1
    row_q.delete(); data_q.delete();
    out_ready = 1'b0;
    pulse_start();
    wcycle(8'h00, 4'hF);
    wcycle(8'h55, 4'hF);
    waited = 0;
    while (!out_valid && waited < 10) begin step(); waited++; end
    chk("bp_present", 32'(out_valid), 32'd1);
    for (int j = 0; j < 5; j++) begin
      chk("bp_hold_row", 32'(out_row), 32'd0);
      chk("bp_hold_data", out_data, rowd[0]);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_row", 32'(out_row), 32'd1);
    chk("bp_next_data", out_data, rowd[1]);
    wcycle(8'hAA, 4'hF);
    wcycle(8'hFF, 4'hF);
    wait_done("bp_done");
    check_queue("bp");

    // Duplicate write to [2][1] keeps first data and flags err
    row_q.delete(); data_q.delete();
    pulse_start();
    wcycle(8'hAA, 4'b0010);
    wcycle(8'hAA, 4'b0010, 8'hFF);
    chk("dup_err", 32'(err), 32'd1);
    wcycle(8'hAA, 4'b1101);
    wcycle(8'h00, 4'hF);
    wcycle(8'h55, 4'hF);
    wcycle(8'hFF, 4'hF);
    wait_done("dup_done");
    check_queue("dup");

    // err survives a new start; then reset in the middle of a run
    row_q.delete(); data_q.delete();
    pulse_start();
    step();
    chk("err_after_start", 32'(err), 32'd1);
    wcycle(8'h00, 4'hF);
    wcycle(8'h55, 4'hF);
    wcycle(8'hAA, 4'b0011);
    wcycle(8'hFF, 4'hF);
    waited = 0;
    while (row_q.size() < 2 && waited < 20) begin step(); waited++; end
    chk("mid_rows_emitted", 32'(row_q.size()), 32'd2);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_row", 32'(out_row), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    step();
    step();
    reset = 1'b1;

    // Strobe while idle
    wcycle(8'h00, 4'b0001);
    chk("idle_strobe_err", 32'(err), 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("err_cleared", 32'(err), 32'd0);

    // Fresh full matrix after reset: no stale bitmap bits
    row_q.delete(); data_q.delete();
    pulse_start();
    full_rows();
    wait_done("post_rst_done");
    check_queue("post_rst");
    chk("post_rst_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
